// File: rtl/operand_input_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// operand_input_conditioner_pkg
//
// Shared constants for the operand input conditioner:
//   - default channel count and debounce window
//   - fabric clock frequency the debounce window is sized against
//   - clog2 helper used to size the debounce counter
// -----------------------------------------------------------------------------
package operand_input_conditioner_pkg;

  // Fabric clock the board-level adder test tops run on.
  localparam int unsigned CLK_FREQ_HZ = 200_000_000;

  // Two operand bits: a = bit 0, b = bit 1.
  localparam int DEFAULT_WIDTH = 2;

  // 10 ms at CLK_FREQ_HZ; comfortably longer than mechanical switch bounce.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 2_000_000;

  // Ceiling log2, used at elaboration time only. Returns the number of bits
  // needed to hold the values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage : operand_input_conditioner_pkg

// File: rtl/operand_input_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//
// One operand bit: two-flop synchroniser, debounce counter, stable level and
// registered rise/fall strobes.
//
// Build option:
//   CONDITIONER_BYPASS_EN - when defined, the debounce counter is removed and
//                           the stable level follows the synchroniser output
//                           every cycle (fast bring-up / simulation build).
//
// Ports:
//   clk    in   fabric clock, rising edge
//   rst    in   synchronous active-high reset
//   raw_in in   asynchronous switch/button level
//   level  out  debounced stable level
//   rise   out  one-cycle strobe when level goes 0->1
//   fall   out  one-cycle strobe when level goes 1->0
// -----------------------------------------------------------------------------
module debounce_channel
  import operand_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic fall
);

  // sync1 may go metastable; nothing but sync2 is allowed to read it.
  logic sync1;
  logic sync2;

`ifdef CONDITIONER_BYPASS_EN

  // NOTE: every register here is written with non-blocking assignments so
  // that all flops sample pre-edge values; a blocking '=' would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      level <= sync2;
      // Strobes compare the incoming value against the level it replaces,
      // so they land in the same cycle the level changes.
      rise  <= sync2 & ~level;
      fall  <= ~sync2 & level;
    end
  end

`else

  localparam int CNT_W = clog2(DEBOUNCE_CYCLES);
  // Counter value on the edge where a differing input is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: every register here is written with non-blocking assignments so
  // that all flops sample pre-edge values; a blocking '=' would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (sync2 == level) begin
        // Any return to the stable level throws away the partial count.
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Input has differed for DEBOUNCE_CYCLES consecutive cycles. The
        // counter is cleared here, so it can never run past CNT_LAST.
        level <= sync2;
        cnt   <= '0;
        rise  <= sync2;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`endif

endmodule : debounce_channel

// File: rtl/operand_input_conditioner.sv
// -----------------------------------------------------------------------------
// operand_input_conditioner
//
// Upstream stage for the board-level adder test designs. Synchronises and
// debounces raw DIP-switch / pushbutton levels and presents clean operand
// bits plus single-cycle change strobes. Operand a = bit 0, b = bit 1 in the
// default two-channel build.
//
// Build option:
//   CONDITIONER_BYPASS_EN - removes the debounce counters (see
//                           debounce_channel); port list is unchanged.
//
// Ports:
//   clk        in   fabric clock, rising edge
//   rst        in   synchronous active-high reset
//   raw_in     in   [WIDTH] asynchronous switch/button levels
//   op_level   out  [WIDTH] debounced stable levels (adder operand bits)
//   op_rise    out  [WIDTH] one-cycle strobe per channel on 0->1
//   op_fall    out  [WIDTH] one-cycle strobe per channel on 1->0
//   op_changed out  OR of all rise/fall strobes, same cycle as the strobes
// -----------------------------------------------------------------------------
module operand_input_conditioner
  import operand_input_conditioner_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] op_level,
  output logic [WIDTH-1:0] op_rise,
  output logic [WIDTH-1:0] op_fall,
  output logic             op_changed
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw_in(raw_in[i]),
      .level (op_level[i]),
      .rise  (op_rise[i]),
      .fall  (op_fall[i])
    );
  end

  // Built only from registered strobes, so raw_in never reaches an output
  // combinationally.
  assign op_changed = |(op_rise | op_fall);

endmodule : operand_input_conditioner

// File: tb/tb_operand_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_operand_input_conditioner
//
// Directed bench for operand_input_conditioner with WIDTH=2,
// DEBOUNCE_CYCLES=8, so a clean step is accepted on the 10th edge counted
// from the first edge that samples the new raw value. Inputs are driven and
// outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_operand_input_conditioner;

  localparam int WIDTH    = 2;
  localparam int DEB      = 8;
  localparam int LATENCY  = DEB + 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] op_level;
  logic [WIDTH-1:0] op_rise;
  logic [WIDTH-1:0] op_fall;
  logic             op_changed;

  int n_vec;
  int n_miss;

  // Bench-side record of the stable level the DUT should currently hold.
  logic [WIDTH-1:0] exp_lvl;

  operand_input_conditioner #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .op_level  (op_level),
    .op_rise   (op_rise),
    .op_fall   (op_fall),
    .op_changed(op_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs packed as {op_level, op_rise, op_fall, op_changed}.
  function automatic logic [6:0] pack_exp(input logic [1:0] lvl,
                                          input logic [1:0] r,
                                          input logic [1:0] f);
    return {lvl, r, f, |(r | f)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then park on the falling edge for drive/sample.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [6:0] outs();
    return {op_level, op_rise, op_fall, op_changed};
  endfunction

  // Apply raw, expect no change for LATENCY-1 edges, acceptance with the
  // matching strobes on edge LATENCY, and quiet strobes one edge later.
  task automatic step_change(input logic [1:0] raw, input logic [1:0] new_lvl,
                             input string tag);
    logic [1:0] r;
    logic [1:0] f;
    raw_in = raw;
    for (int e = 1; e < LATENCY; e++) begin
      step();
      check({tag, " hold"}, 32'(outs()), 32'(pack_exp(exp_lvl, 2'b00, 2'b00)));
    end
    step();
    r = new_lvl & ~exp_lvl;
    f = ~new_lvl & exp_lvl;
    check({tag, " accept"}, 32'(outs()), 32'(pack_exp(new_lvl, r, f)));
    exp_lvl = new_lvl;
    step();
    check({tag, " after"}, 32'(outs()), 32'(pack_exp(new_lvl, 2'b00, 2'b00)));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    exp_lvl = 2'b00;
    rst     = 1'b1;
    raw_in  = 2'b11;

    // Reset held 3 cycles with both raw inputs high: everything stays 0.
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      step();
      check("reset outs", 32'(outs()), 32'(pack_exp(2'b00, 2'b00, 2'b00)));
    end
    rst = 1'b0;

    // Full latency after release; both channels rise together.
    step_change(2'b11, 2'b11, "post reset rise");

    // Both fall together, then a clean step on channel 0 only.
    step_change(2'b00, 2'b00, "both fall");
    step_change(2'b01, 2'b01, "clean step");

    // Glitch: raw[1] high for 5 cycles, then low. Nothing may change.
    raw_in = 2'b11;
    for (int c = 0; c < 5; c++) begin
      step();
      check("glitch high", 32'(outs()), 32'(pack_exp(2'b01, 2'b00, 2'b00)));
    end
    raw_in = 2'b01;
    for (int c = 0; c < 12; c++) begin
      step();
      check("glitch low", 32'(outs()), 32'(pack_exp(2'b01, 2'b00, 2'b00)));
    end

    // Full latency again proves the glitch left no partial count behind.
    step_change(2'b11, 2'b11, "post glitch rise");

    // Bounce on raw[0]: 0,1,0,1 for 3 cycles each, then hold 0.
    for (int c = 0; c < 12; c++) begin
      raw_in = {1'b1, ((c / 3) % 2 == 1)};
      step();
      check("bounce", 32'(outs()), 32'(pack_exp(2'b11, 2'b00, 2'b00)));
    end
    step_change(2'b10, 2'b10, "bounce settle");

    // Simultaneous rise from 00.
    step_change(2'b00, 2'b00, "clear");
    step_change(2'b11, 2'b11, "simultaneous");
    step_change(2'b00, 2'b00, "clear2");

    // Reset mid-count: raw[0] rises, counter reaches 5 after 7 edges.
    raw_in = 2'b01;
    for (int c = 0; c < 7; c++) begin
      step();
      check("pre mid rst", 32'(outs()), 32'(pack_exp(2'b00, 2'b00, 2'b00)));
    end
    rst = 1'b1;
    step();
    check("mid rst", 32'(outs()), 32'(pack_exp(2'b00, 2'b00, 2'b00)));
    rst = 1'b0;
    exp_lvl = 2'b00;
    step_change(2'b01, 2'b01, "after mid rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_operand_input_conditioner

// File: doc/operand_input_conditioner.md
Name: operand_input_conditioner

Overview:
- Upstream stage for the board-level adder test designs.
- Takes raw, asynchronous DIP-switch/pushbutton levels from the board, synchronises them to the fabric clock and debounces them.
- Presents clean operand bits plus single-cycle change strobes to the combinational adder stage (operand a = bit 0, b = bit 1 in the default build).
- One instance per test top; outputs feed the adder inputs and the LED capture logic directly.

Parameters:
- WIDTH, 2, number of independent input channels (operand bits).
- DEBOUNCE_CYCLES, 2000000, consecutive clock cycles a synchronised input must differ from the stable level before it is accepted (10 ms at 200 MHz); legal range 2 to 2^24.
- CNT_W, derived as clog2(DEBOUNCE_CYCLES), counter width; localparam, not overridable.

Ports:
- clk, input, 1, fabric clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- raw_in, input, WIDTH, asynchronous switch/button levels.
- op_level, output, WIDTH, debounced stable levels (operand bits to the adder).
- op_rise, output, WIDTH, one-cycle pulse per channel when op_level goes 0->1.
- op_fall, output, WIDTH, one-cycle pulse per channel when op_level goes 1->0.
- op_changed, output, 1, OR-reduction of op_rise|op_fall; same cycle as the pulses.

Behaviour:
- Reset (rst=1 at a clock edge): both synchroniser stages, stable levels, counters and pulse outputs go to 0. Reset dominates every other event on that edge.
- Synchroniser:
  - two flops per channel, sync1 <= raw_in, sync2 <= sync1;
  - no logic between the stages;
  - sync2 is the only value the debounce logic sees.
- Debounce, per channel, evaluated every cycle:
  - sync2 == op_level: counter <= 0.
  - sync2 != op_level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != op_level and counter == DEBOUNCE_CYCLES-1: op_level <= sync2, counter <= 0, and the matching rise/fall pulse is registered the same edge.
- Glitch rejection: any cycle where sync2 returns to op_level clears the counter. The count restarts from 0; no partial credit.
- Latency: a clean raw_in step reaches op_level 2 + DEBOUNCE_CYCLES clock edges after the first edge that samples the new value. Pulses assert in the same cycle op_level changes.
- Pulses are registered; they are high for exactly one cycle and never asserted in consecutive cycles on the same channel.
- Channels are fully independent. Simultaneous acceptance on several channels asserts several pulse bits in the same cycle, and op_changed is 1 for that one cycle.
- Counter never wraps; it saturates at its acceptance point by construction.
- Reset mid-count: counter cleared and op_level forced to 0. If raw_in is held at 1 through reset, the full 2 + DEBOUNCE_CYCLES latency applies after release, then op_rise pulses.
- No combinational path from raw_in to any output.

Optional Feature:
- Macro: CONDITIONER_BYPASS_EN.
- Defined (simulation/fast bring-up build):
  - debounce counters are removed;
  - op_level <= sync2 every cycle;
  - rise/fall pulses are derived from op_level vs sync2, so latency is 3 edges;
  - synchroniser is retained.
- Undefined (default, hardware build): full debounce as above.
- Port list is identical in both builds.

Decomposition:
- Shared package/include holds:
  - default WIDTH (2) and DEBOUNCE_CYCLES (2000000);
  - the clock frequency constant (200 MHz);
  - the clog2 function used for CNT_W.
- One sub-module, debounce_channel. It is single-bit and contains the synchroniser, counter, stable level and rise/fall pulse.
- The top generates WIDTH instances and ORs the pulses into op_changed.

Test Plan (bench uses DEBOUNCE_CYCLES=8, WIDTH=2):
- Reset: rst=1 for 3 cycles with raw_in=2'b11 -> all outputs 0 during reset; op_level=2'b11 exactly 10 edges after release; op_rise=2'b11 and op_changed=1 for one cycle.
- Clean step: raw_in 2'b00 -> 2'b01 held -> op_level[0]=1 after 10 edges; single op_rise[0] pulse; op_fall=0; op_level[1] stays 0.
- Glitch: raw_in[1] high for 5 cycles then low -> op_level[1] stays 0; no pulses; counter back to 0.
- Bounce then settle: raw_in[0] toggles every 3 cycles for 12 cycles, then holds 0 from 1 -> exactly one op_fall[0] pulse, 10 edges after the last transition.
- Simultaneous: raw_in 2'b00 -> 2'b11 on one edge -> op_rise=2'b11 in the same cycle; op_changed high for one cycle only.
- Reset mid-count: raw_in[0] rises, rst pulsed at count 5 -> no pulse before reset; op_level[0]=0 after reset; pulse 10 edges after rst release.
